// File: rtl/lvg_loader.sv
`default_nettype none
// ============================================================================
// Module   : lvg_loader
// Brief    : Streams 32 words into the lvg 4x4 right/left matrix inputs, then
//            issues load-right, load-left and compute, and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module lvg_loader #(
    parameter int DATA_W         = 32,
    parameter int COMPUTE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [16*DATA_W-1:0] r_flat,
    output logic [16*DATA_W-1:0] l_flat,
    output logic [15:0]          instr,
    output logic                 lvg_rst,
    output logic                 busy,
    output logic                 done
);

    localparam int              CC_W    = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CC_W-1:0] CC_LAST = CC_W'(COMPUTE_CYCLES - 1);

    localparam logic [7:0] OP_NONE    = 8'd0;
    localparam logic [7:0] OP_LOAD_L  = 8'd1;
    localparam logic [7:0] OP_LOAD_R  = 8'd2;
    localparam logic [7:0] OP_COMPUTE = 8'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV_R  = 3'd1,
        S_RECV_L  = 3'd2,
        S_ISSUE_R = 3'd3,
        S_ISSUE_L = 3'd4,
        S_COMPUTE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        wc_q, wc_d;
    logic [CC_W-1:0]   cc_q, cc_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] r_q [16];
    logic [DATA_W-1:0] l_q [16];
    logic              w_accept;

    assign w_accept = in_valid && ((state_q == S_RECV_R) || (state_q == S_RECV_L));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            cc_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            cc_q    <= cc_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wc_d     = w_accept ? wc_q + 5'd1 : wc_q;
        cc_d     = '0;
        busy_d   = busy_q;
        in_ready = 1'b0;
        lvg_rst  = 1'b0;
        done     = 1'b0;
        instr    = {8'd0, OP_NONE};

        if (w_accept && (wc_q == 5'd0)) begin
            busy_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                lvg_rst = 1'b1;
                state_d = S_RECV_R;
            end
            S_RECV_R: begin
                lvg_rst  = 1'b1;
                in_ready = 1'b1;
                if (w_accept && (wc_q == 5'd15)) state_d = S_RECV_L;
            end
            S_RECV_L: begin
                lvg_rst  = 1'b1;
                in_ready = 1'b1;
                if (w_accept && (wc_q == 5'd31)) state_d = S_ISSUE_R;
            end
            S_ISSUE_R: begin
                instr   = {8'd0, OP_LOAD_R};
                state_d = S_ISSUE_L;
            end
            S_ISSUE_L: begin
                instr   = {8'd0, OP_LOAD_L};
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                instr = {8'd0, OP_COMPUTE};
                if (cc_q == CC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cc_d = cc_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_RECV_R;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Matrix storage only changes on an accepted word, so it is stable while the engine runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                r_q[k] <= '0;
                l_q[k] <= '0;
            end
        end else if (w_accept) begin
            if (!wc_q[4]) begin
                r_q[wc_q[3:0]] <= in_data;
            end else begin
                l_q[wc_q[3:0]] <= in_data;
            end
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_flat
        assign r_flat[k*DATA_W +: DATA_W] = r_q[k];
        assign l_flat[k*DATA_W +: DATA_W] = l_q[k];
    end

    assign busy = busy_q;

endmodule
`default_nettype wire
